// File: rtl/morse_pkg.sv
// Shared state encoding, widths and default timing constants for the Morse
// receive controller.
package morse_pkg;

  localparam int TICK_DIV_DEF = 12_500_000;
  localparam int DASH_T_DEF   = 4;
  localparam int GAP_T_DEF    = 7;
  localparam int MAX_EL_DEF   = 5;

  localparam int CODE_W = 5;
  localparam int LEN_W  = 3;
  localparam int UC_W   = 3;

  localparam logic [UC_W-1:0] UC_MAX = '1;

  // Encoding is exported as-is on StateY.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MARK  = 2'b01,
    SPACE = 2'b10,
    DONE  = 2'b11
  } state_e;

  function automatic logic [UC_W-1:0] sat_inc(input logic [UC_W-1:0] v);
    return (v == UC_MAX) ? v : v + UC_W'(1);
  endfunction

endpackage

// File: rtl/morse_rx_ctrl_if.sv
// Key input, character handshake and status bundle between the receive
// controller (slave) and its environment (master).
interface morse_rx_if;
  logic                         KQ;
  logic                         ReadyX;
  logic                         ValidY;
  logic [morse_pkg::CODE_W-1:0] CodeQ;
  logic [morse_pkg::LEN_W-1:0]  LenQ;
  logic                         ErrY;
  logic                         DropY;
  logic [1:0]                   StateY;

  modport slave (
    input  KQ, ReadyX,
    output ValidY, CodeQ, LenQ, ErrY, DropY, StateY
  );

  modport master (
    output KQ, ReadyX,
    input  ValidY, CodeQ, LenQ, ErrY, DropY, StateY
  );
endinterface

// File: rtl/morse_tbase.sv
// Element time base: prescaler producing one tick per unit T, plus a
// saturating count of whole units since the last key edge.
module morse_tbase
  import morse_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            en_i,
  output logic            tick_o,
  output logic [UC_W-1:0] uc_o
);

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   CNT_TOP = PW'(TICK_DIV - 1);

  logic [PW-1:0]   cnt_q, cnt_d, cnt_base;
  logic [UC_W-1:0] uc_q, uc_d, uc_base;

  // The edge cycle itself is the first cycle of the new unit, so a level
  // held for k*TICK_DIV cycles reads UC = k when the opposite edge shows.
  always_comb begin
    cnt_base = clear_i ? '0 : cnt_q;
    uc_base  = clear_i ? '0 : uc_q;
    tick_o   = en_i && (cnt_base == CNT_TOP);
    cnt_d    = cnt_base;
    uc_d     = uc_base;
    if (en_i) begin
      if (tick_o) begin
        cnt_d = '0;
        uc_d  = sat_inc(uc_base);
      end else begin
        cnt_d = cnt_base + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      uc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      uc_q  <= uc_d;
    end
  end

  assign uc_o = uc_q;

endmodule

// File: rtl/morse_rx_ctrl.sv
// Morse receive sequencer: classifies marks, assembles up to MAX_EL elements
// per character and hands finished characters out through a holding register.
module morse_rx_ctrl
  import morse_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DASH_T   = DASH_T_DEF,
  parameter int GAP_T    = GAP_T_DEF,
  parameter int MAX_EL   = MAX_EL_DEF
) (
  input  logic      C,
  input  logic      nR,
  morse_rx_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_EL);

  state_e            state_q, state_d;
  logic              kqd_q;
  logic              rise, fall, el, gap, hs, tb_en, tick_unused;
  logic [UC_W-1:0]   uc;
  logic [CODE_W-1:0] sr_q, sr_d, code_q, code_d;
  logic [LEN_W-1:0]  n_q, n_d, len_q, len_d;
  logic              ov_q, ov_d, vld_q, vld_d, err_q, err_d, drop_q, drop_d;

  assign rise  = bus.KQ & ~kqd_q;
  assign fall  = ~bus.KQ & kqd_q;
  assign tb_en = rise | (state_q == MARK) | (state_q == SPACE);

  // Only the unit count is needed here; the raw tick is left unused.
  morse_tbase #(.TICK_DIV(TICK_DIV)) u_tbase (
    .clk    (C),
    .rst_n  (nR),
    .clear_i(rise | fall),
    .en_i   (tb_en),
    .tick_o (tick_unused),
    .uc_o   (uc)
  );

  assign el  = (int'(uc) >= DASH_T);
  assign gap = (int'(uc) >= GAP_T);
  assign hs  = vld_q & bus.ReadyX;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    n_d     = n_q;
    ov_d    = ov_q;
    vld_d   = vld_q;
    code_d  = code_q;
    len_d   = len_q;
    err_d   = err_q;
    drop_d  = 1'b0;

    if (hs) vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MARK;
          sr_d    = '0;
          n_d     = '0;
          ov_d    = 1'b0;
        end
      end
      MARK: begin
        if (fall) begin
          state_d = SPACE;
          if (n_q < MAX_N) begin
            sr_d = {sr_q[CODE_W-2:0], el};
            n_d  = n_q + LEN_W'(1);
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      SPACE: begin
        if (rise)     state_d = MARK;
        else if (gap) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        // A press landing exactly here would otherwise be swallowed.
        if (rise) begin
          state_d = MARK;
          sr_d    = '0;
          n_d     = '0;
          ov_d    = 1'b0;
        end
        if (!vld_q || hs) begin
          code_d = sr_q;
          len_d  = n_q;
          err_d  = ov_q;
          vld_d  = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= IDLE;
      kqd_q   <= 1'b0;
      sr_q    <= '0;
      n_q     <= '0;
      ov_q    <= 1'b0;
      vld_q   <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kqd_q   <= bus.KQ;
      sr_q    <= sr_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      len_q   <= len_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.ValidY = vld_q;
  assign bus.CodeQ  = code_q;
  assign bus.LenQ   = len_q;
  assign bus.ErrY   = err_q;
  assign bus.DropY  = drop_q;
  assign bus.StateY = state_q;

endmodule

// File: tb/tb_morse_rx_ctrl.sv
// Bench for morse_rx_ctrl at TICK_DIV = 4: directed characters, boundary cases
// and random characters checked against a duration-based reference model.
module tb_morse_rx_ctrl;

  localparam int TD     = 4;
  localparam int DASH_T = 4;
  localparam int GAP_T  = 7;
  localparam int MAX_EL = 5;
  localparam int GAPC   = GAP_T * TD;

  logic C = 1'b0;
  logic nR;
  morse_rx_if bus();

  morse_rx_ctrl #(.TICK_DIV(TD), .DASH_T(DASH_T), .GAP_T(GAP_T), .MAX_EL(MAX_EL)) dut (
    .C  (C),
    .nR (nR),
    .bus(bus)
  );

  always #5 C = ~C;

  int cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Observers
  logic       rdy_rand = 1'b0;
  int         drop_cnt = 0, vrise_cyc = -1, unstable = 0, rel_cyc = 0;
  logic       vld_prev = 1'b0, rdy_prev = 1'b0;
  logic [8:0] held_prev = '0;
  logic [8:0] got[$];

  always @(negedge C) begin
    logic [8:0] cur;
    cur = {bus.ErrY, bus.LenQ, bus.CodeQ};
    if (bus.ValidY && !vld_prev) vrise_cyc = cyc;
    if (bus.DropY) drop_cnt++;
    if (vld_prev && !rdy_prev && bus.ValidY && cur != held_prev) unstable++;
    if (bus.ValidY && bus.ReadyX) got.push_back(cur);
    vld_prev  = bus.ValidY;
    rdy_prev  = bus.ReadyX;
    held_prev = cur;
  end

  // Reference: character = first MAX_EL elements read as a binary number
  // (dash = 1, first element most significant); overflow if more were keyed.
  function automatic logic [8:0] model(input int marks[$]);
    int         total, l;
    logic [4:0] code;
    total = marks.size();
    l     = (total < MAX_EL) ? total : MAX_EL;
    code  = '0;
    for (int i = 0; i < l; i++)
      if (marks[i] >= DASH_T * TD) code = code + 5'(1 << (l - 1 - i));
    return {(total > MAX_EL), 3'(l), code};
  endfunction

  task automatic drive(input logic v, input int n);
    bus.KQ = v;
    for (int i = 0; i < n; i++) begin
      if (rdy_rand) bus.ReadyX = 1'($urandom_range(0, 1));
      @(posedge C);
      #1;
    end
  endtask

  task automatic send_char(input int marks[$], input int sp[$], input int gap);
    for (int i = 0; i < marks.size(); i++) begin
      drive(1'b1, marks[i]);
      if (i < marks.size() - 1) drive(1'b0, sp[i]);
      else begin
        rel_cyc = cyc;
        drive(1'b0, gap);
      end
    end
  endtask

  task automatic send_str(input string s, input int dot, input int dash, input int sp, input int gap);
    int m[$];
    int q[$];
    for (int i = 0; i < s.len(); i++) begin
      m.push_back((s[i] == "-") ? dash : dot);
      q.push_back(sp);
    end
    send_char(m, q, gap);
  endtask

  task automatic test_reset;
    nR = 1'b0; bus.KQ = 1'b0; bus.ReadyX = 1'b0;
    repeat (3) @(posedge C);
    #1;
    n_tests++;
    if ({bus.ValidY, bus.CodeQ, bus.LenQ, bus.ErrY, bus.DropY} !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b exp 0", {bus.ValidY, bus.CodeQ, bus.LenQ, bus.ErrY, bus.DropY});
    end
    n_tests++;
    if (bus.StateY !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b exp 00", bus.StateY); end
    #3 nR = 1'b1;
    repeat (3) @(posedge C);
    #1;
    n_tests++;
    if (bus.StateY !== 2'b00 || bus.ValidY !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: state %b valid %b exp 00/0", bus.StateY, bus.ValidY);
    end
  endtask

  task automatic test_digit0;
    bus.ReadyX = 1'b1; got.delete(); vrise_cyc = -1;
    send_str("-----", 0, 5 * TD, 2 * TD, 8 * TD);
    n_tests++;
    if (got.size() != 1) begin n_fail++; $display("FAIL digit0_count: got %0d exp 1", got.size()); end
    else if (got[0] !== 9'b0_101_11111) begin n_fail++; $display("FAIL digit0_char: got %b exp 010111111", got[0]); end
    n_tests++;
    if (vrise_cyc - rel_cyc != GAPC + 2) begin
      n_fail++; $display("FAIL digit0_latency: got %0d exp %0d", vrise_cyc - rel_cyc, GAPC + 2);
    end
  endtask

  task automatic test_letter_a;
    bus.ReadyX = 1'b1; got.delete();
    send_str(".-", 2 * TD, 4 * TD, 2 * TD, GAPC + 12);
    send_str(".", DASH_T * TD - 1, 0, 0, GAPC + 12);
    send_str("-", 0, DASH_T * TD, 0, GAPC + 12);
    n_tests++;
    if (got.size() != 3) begin n_fail++; $display("FAIL letter_a_count: got %0d exp 3", got.size()); end
    else begin
      if (got[0] !== 9'b0_010_00001) begin n_fail++; $display("FAIL letter_a_char: got %b exp 001000001", got[0]); end
      n_tests++;
      if (got[1] !== 9'b0_001_00000) begin n_fail++; $display("FAIL dash_minus1_is_dot: got %b exp 000100000", got[1]); end
      n_tests++;
      if (got[2] !== 9'b0_001_00001) begin n_fail++; $display("FAIL dash_exact_is_dash: got %b exp 000100001", got[2]); end
    end
  endtask

  task automatic test_overflow;
    bus.ReadyX = 1'b1; got.delete();
    send_str("......", TD, 0, TD, GAPC + 12);
    n_tests++;
    if (got.size() != 1) begin n_fail++; $display("FAIL overflow_count: got %0d exp 1", got.size()); end
    else if (got[0] !== 9'b1_101_00000) begin n_fail++; $display("FAIL overflow_char: got %b exp 110100000", got[0]); end
  endtask

  task automatic test_backpressure;
    bus.ReadyX = 1'b0; got.delete(); drop_cnt = 0; unstable = 0;
    send_str(".....", TD, 4 * TD, TD, GAPC + 12);
    n_tests++;
    if ({bus.ValidY, bus.ErrY, bus.LenQ, bus.CodeQ} !== 10'b1_0_101_00000) begin
      n_fail++; $display("FAIL bp_first_held: got %b exp 1010100000", {bus.ValidY, bus.ErrY, bus.LenQ, bus.CodeQ});
    end
    send_str(".----", TD, 4 * TD, TD, GAPC + 12);
    n_tests++;
    if (drop_cnt != 1) begin n_fail++; $display("FAIL bp_drop_pulses: got %0d exp 1", drop_cnt); end
    n_tests++;
    if ({bus.ValidY, bus.ErrY, bus.LenQ, bus.CodeQ} !== 10'b1_0_101_00000) begin
      n_fail++; $display("FAIL bp_still_held: got %b exp 1010100000", {bus.ValidY, bus.ErrY, bus.LenQ, bus.CodeQ});
    end
    bus.ReadyX = 1'b1;
    @(posedge C);
    #1;
    n_tests++;
    if (bus.ValidY !== 1'b0) begin n_fail++; $display("FAIL bp_valid_clear: got %b exp 0", bus.ValidY); end
    n_tests++;
    if (got.size() != 1 || unstable != 0) begin
      n_fail++; $display("FAIL bp_transfer: transfers %0d unstable %0d exp 1/0", got.size(), unstable);
    end
  endtask

  task automatic test_race;
    bus.ReadyX = 1'b1; got.delete();
    drive(1'b1, TD);
    drive(1'b0, 1);
    n_tests++;
    if (bus.StateY !== 2'b10) begin n_fail++; $display("FAIL race_space_state: got %b exp 10", bus.StateY); end
    drive(1'b0, GAPC - 1);
    drive(1'b1, 1);
    n_tests++;
    if (bus.StateY !== 2'b01 || bus.ValidY !== 1'b0 || got.size() != 0) begin
      n_fail++; $display("FAIL race_rise_wins: state %b valid %b transfers %0d exp 01/0/0", bus.StateY, bus.ValidY, got.size());
    end
    drive(1'b1, TD - 1);
    drive(1'b0, GAPC + 12);
    n_tests++;
    if (got.size() != 1) begin n_fail++; $display("FAIL race_count: got %0d exp 1", got.size()); end
    else if (got[0] !== 9'b0_010_00000) begin n_fail++; $display("FAIL race_char: got %b exp 001000000", got[0]); end
  endtask

  task automatic test_reset_mid;
    bus.ReadyX = 1'b0; got.delete();
    send_str(".", TD, 0, 0, GAPC + 12);
    n_tests++;
    if (bus.ValidY !== 1'b1) begin n_fail++; $display("FAIL rstmid_held: got %b exp 1", bus.ValidY); end
    drive(1'b1, 6);
    #3 nR = 1'b0;
    #1;
    n_tests++;
    if ({bus.ValidY, bus.CodeQ, bus.LenQ, bus.ErrY, bus.DropY, bus.StateY} !== 13'd0) begin
      n_fail++; $display("FAIL rstmid_async: got %b exp 0", {bus.ValidY, bus.CodeQ, bus.LenQ, bus.ErrY, bus.DropY, bus.StateY});
    end
    bus.KQ = 1'b0;
    repeat (2) @(posedge C);
    #4 nR = 1'b1;
    @(posedge C);
    #1;
    bus.ReadyX = 1'b1; got.delete();
    send_str("-.", TD, 4 * TD, 2 * TD, GAPC + 12);
    n_tests++;
    if (got.size() != 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d exp 1", got.size()); end
    else if (got[0] !== 9'b0_010_00010) begin n_fail++; $display("FAIL rstmid_next_char: got %b exp 001000010", got[0]); end
  endtask

  task automatic test_random;
    logic [8:0] exp_q[$];
    got.delete(); drop_cnt = 0; unstable = 0; rdy_rand = 1'b1;
    for (int c = 0; c < 12; c++) begin
      int m[$];
      int s[$];
      int nel;
      nel = $urandom_range(1, 7);
      for (int e = 0; e < nel; e++) begin
        m.push_back($urandom_range(1, 7 * TD));
        s.push_back($urandom_range(1, GAPC));
      end
      exp_q.push_back(model(m));
      send_char(m, s, $urandom_range(GAPC + 3, GAPC + 12));
    end
    rdy_rand = 1'b0; bus.ReadyX = 1'b1;
    repeat (3) @(posedge C);
    #1;
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d exp %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_char%0d: got %b exp %b", i, got[i], exp_q[i]); end
      end
    end
    n_tests++;
    if (drop_cnt != 0 || unstable != 0) begin
      n_fail++; $display("FAIL rand_handshake: drops %0d unstable %0d exp 0/0", drop_cnt, unstable);
    end
  endtask

  initial begin
    test_reset();
    test_digit0();
    test_letter_a();
    test_overflow();
    test_backpressure();
    test_race();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
